// File: rtl/calc1_pkg.sv
// Shared encodings and types for the calc1 request/response port.
package calc1_pkg;
  localparam int DATA_W = 32;

  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_SHL = 4'd5;
  localparam logic [0:3] CMD_SHR = 4'd6;

  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_WAIT, ST_RESP} state_e;
endpackage

// File: rtl/calc1_alu_core.sv
// Combinational calc1 arithmetic and error rules; reusable as a reference model.
module calc1_alu_core
  import calc1_pkg::*;
(
  input  logic [0:3]        cmd_i,
  input  logic [0:DATA_W-1] op1_i,
  input  logic [0:DATA_W-1] op2_i,
  output logic [0:DATA_W-1] result_o,
  output logic [0:1]        resp_o
);
  logic [DATA_W:0] sum;

  always_comb begin
    sum      = {1'b0, op1_i} + {1'b0, op2_i};
    result_o = '0;
    resp_o   = RESP_ERR;
    case (cmd_i)
      CMD_ADD: if (!sum[DATA_W]) begin
        result_o = sum[DATA_W-1:0];
        resp_o   = RESP_OK;
      end
      CMD_SUB: if (op2_i <= op1_i) begin
        result_o = op1_i - op2_i;
        resp_o   = RESP_OK;
      end
      // Shift amount is the low five bits of operand 2 (bit 31 is the LSB).
      CMD_SHL: begin
        result_o = op1_i << op2_i[27:31];
        resp_o   = RESP_OK;
      end
      CMD_SHR: begin
        result_o = op1_i >> op2_i[27:31];
        resp_o   = RESP_OK;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/calc1_port_responder.sv
// Device end of the calc1 port: two-cycle request capture, fixed-latency
// one-cycle response, back-to-back accept on the response cycle.
module calc1_port_responder
  import calc1_pkg::*;
#(
  parameter int RESP_LATENCY = 1
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [0:3]        req_cmd_in,
  input  logic [0:DATA_W-1] req_data_in,
  output logic [0:1]        out_resp,
  output logic [0:DATA_W-1] out_data,
  output logic              busy
);
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [0:3]        cmd_q, cmd_d;
  logic [0:DATA_W-1] op1_q, op1_d, res_q, res_d;
  logic [0:1]        rsp_q, rsp_d;
  logic [0:DATA_W-1] alu_res;
  logic [0:1]        alu_rsp;

  calc1_alu_core u_alu (
    .cmd_i   (cmd_q),
    .op1_i   (op1_q),
    .op2_i   (req_data_in),
    .result_o(alu_res),
    .resp_o  (alu_rsp)
  );

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= CMD_NOP;
      op1_q   <= '0;
      res_q   <= '0;
      rsp_q   <= RESP_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      res_q   <= res_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    res_d   = res_q;
    rsp_d   = rsp_q;
    case (state_q)
      ST_OP2: begin
        res_d = alu_res;
        rsp_d = alu_rsp;
        if (RESP_LATENCY == 1) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 4'(RESP_LATENCY - 1);
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      // IDLE and RESP share the accept path; RESP falls back to IDLE.
      default: begin
        if (state_q == ST_RESP) state_d = ST_IDLE;
        if (req_cmd_in != CMD_NOP) begin
          cmd_d   = req_cmd_in;
          op1_d   = req_data_in;
          state_d = ST_OP2;
        end
      end
    endcase
  end

  assign out_resp = (state_q == ST_RESP) ? rsp_q : RESP_NONE;
  assign out_data = (state_q == ST_RESP) ? res_q : '0;
  assign busy     = (state_q == ST_OP2) || (state_q == ST_WAIT);
endmodule

// File: tb/tb_calc1_port_responder.sv
// Scoreboard bench: one responder at latency 1, one at latency 4.
module tb_calc1_port_responder;
  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [0:3]  cmd1 = '0, cmd4 = '0;
  logic [0:31] data1 = '0, data4 = '0;
  logic [0:1]  out_resp1, out_resp4;
  logic [0:31] out_data1, out_data4;
  logic        busy1, busy4;

  logic [33:0] q1[$];
  logic [33:0] q4[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 c_clk = ~c_clk;

  calc1_port_responder #(.RESP_LATENCY(1)) u_dut1 (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(cmd1), .req_data_in(data1),
    .out_resp(out_resp1), .out_data(out_data1), .busy(busy1));

  calc1_port_responder #(.RESP_LATENCY(4)) u_dut4 (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(cmd4), .req_data_in(data4),
    .out_resp(out_resp4), .out_data(out_data4), .busy(busy4));

  // Scoreboard: every response pops the oldest expectation of its port.
  always @(negedge c_clk) begin
    logic [33:0] e;
    if (!reset) begin
      n_vec++;
      if (out_resp1 != 2'd0) begin
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL lat1_unexpected got resp=%0d data=%h want none", out_resp1, out_data1);
        end else begin
          e = q1.pop_front();
          if ({out_resp1, out_data1} !== e) begin
            n_err++;
            $display("FAIL lat1_resp got %0d/%h want %0d/%h", out_resp1, out_data1, e[33:32], e[31:0]);
          end
        end
      end else if (out_data1 !== 32'd0) begin
        n_err++;
        $display("FAIL lat1_idle_data got %h want 0", out_data1);
      end
      n_vec++;
      if (out_resp4 != 2'd0) begin
        if (q4.size() == 0) begin
          n_err++;
          $display("FAIL lat4_unexpected got resp=%0d data=%h want none", out_resp4, out_data4);
        end else begin
          e = q4.pop_front();
          if ({out_resp4, out_data4} !== e) begin
            n_err++;
            $display("FAIL lat4_resp got %0d/%h want %0d/%h", out_resp4, out_data4, e[33:32], e[31:0]);
          end
        end
      end else if (out_data4 !== 32'd0) begin
        n_err++;
        $display("FAIL lat4_idle_data got %h want 0", out_data4);
      end
    end
  end

  // Drives command+op1 then op2; returns #1 after the command edge.
  task automatic send(input int sel, input logic [3:0] c, input logic [31:0] a, b,
                      input logic [1:0] er, input logic [31:0] ed);
    @(posedge c_clk); #1;
    if (sel == 1) begin cmd1 = c; data1 = a; q1.push_back({er, ed}); end
    else          begin cmd4 = c; data4 = a; q4.push_back({er, ed}); end
    @(posedge c_clk); #1;
    if (sel == 1) begin cmd1 = '0; data1 = b; end
    else          begin cmd4 = '0; data4 = b; end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((q1.size() != 0 || q4.size() != 0 || busy1 || busy4) && k < 60) begin
      @(negedge c_clk); k++;
    end
    repeat (2) @(negedge c_clk);
    n_vec++;
    if (q1.size() != 0 || q4.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain got pending=%0d/%0d want 0/0", tag, q1.size(), q4.size());
      q1.delete(); q4.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge c_clk);
    n_vec++;
    if ({out_resp1, out_data1, busy1, out_resp4, out_data4, busy4} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %0d/%h/%b %0d/%h/%b want all 0",
               out_resp1, out_data1, busy1, out_resp4, out_data4, busy4);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    send(1, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000);
    @(negedge c_clk);
    n_vec++;
    if (busy1 !== 1'b1 || out_resp1 !== 2'd0) begin
      n_err++; $display("FAIL add_op2_cycle got busy=%b resp=%0d want 1/0", busy1, out_resp1);
    end
    @(negedge c_clk);
    n_vec++;
    if (out_resp1 !== 2'd1 || busy1 !== 1'b0) begin
      n_err++; $display("FAIL add_latency got resp=%0d busy=%b want 1/0", out_resp1, busy1);
    end
    @(negedge c_clk);
    n_vec++;
    if (out_resp1 !== 2'd0) begin
      n_err++; $display("FAIL add_one_cycle got resp=%0d want 0", out_resp1);
    end
    send(1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0);
    send(1, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE);
    send(1, 4'd1, 32'h8000_0000, 32'h7FFF_FFFF, 2'd1, 32'hFFFF_FFFF);
    drain("add");
  endtask

  task automatic test_sub();
    send(1, 4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0);
    send(1, 4'd2, 32'h0000_000F, 32'h0000_0001, 2'd1, 32'h0000_000E);
    send(1, 4'd2, 32'h1234_5678, 32'h1234_5678, 2'd1, 32'h0);
    drain("sub");
  endtask

  task automatic test_shift();
    logic [31:0] one = 32'h1;
    for (int k = 0; k < 32; k++)
      send(1, 4'd5, 32'h1, 32'(k), 2'd1, one << k);
    send(1, 4'd6, 32'h8000_0000, 32'h0000_0021, 2'd1, 32'h4000_0000);
    send(1, 4'd6, 32'hF000_000F, 32'hFFFF_FFE4, 2'd1, 32'h0F00_0000);
    send(1, 4'd3, 32'h5, 32'h1, 2'd2, 32'h0);
    send(1, 4'd4, 32'h5, 32'h1, 2'd2, 32'h0);
    send(1, 4'd15, 32'h5, 32'h1, 2'd2, 32'h0);
    drain("shift");
  endtask

  task automatic test_latency();
    send(4, 4'd1, 32'h0000_0010, 32'h0000_0020, 2'd1, 32'h0000_0030);
    @(negedge c_clk);
    n_vec++;
    if (busy4 !== 1'b1) begin
      n_err++; $display("FAIL lat4_busy_op2 got %b want 1", busy4);
    end
    @(posedge c_clk);
    for (int n = 0; n < 4; n++) begin
      @(negedge c_clk);
      n_vec++;
      if (busy4 !== (n < 3) || (out_resp4 != 2'd0) !== (n == 3)) begin
        n_err++;
        $display("FAIL lat4_timing_%0d got busy=%b resp=%0d want %b/%0d", n, busy4, out_resp4,
                 n < 3, (n == 3) ? 1 : 0);
      end
      if (n == 0) begin cmd4 = 4'd2; data4 = 32'hDEAD_BEEF; end
      if (n == 1) begin cmd4 = '0; data4 = '0; end
      if (n == 3) begin
        cmd4 = 4'd2; data4 = 32'h0000_000F;
        q4.push_back({2'd1, 32'h0000_000E});
      end
    end
    @(negedge c_clk);
    n_vec++;
    if (busy4 !== 1'b1) begin
      n_err++; $display("FAIL b2b_accept got busy=%b want 1", busy4);
    end
    cmd4 = '0; data4 = 32'h0000_0001;
    drain("latency");
  endtask

  task automatic test_reset_mid();
    send(4, 4'd1, 32'h1, 32'h2, 2'd1, 32'h3);
    @(posedge c_clk);
    @(negedge c_clk);
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (busy4 !== 1'b0 || out_resp4 !== 2'd0 || out_data4 !== 32'd0) begin
      n_err++; $display("FAIL mid_reset got busy=%b resp=%0d want 0/0", busy4, out_resp4);
    end
    q4.delete();
    @(negedge c_clk);
    #2 reset = 1'b0;
    repeat (8) @(negedge c_clk);
    send(4, 4'd1, 32'h0000_0100, 32'h0000_0023, 2'd1, 32'h0000_0123);
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_latency();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
